adc_link_trainer: RTL and testbench
===================================

# adc_link_trainer

Automatic link-training sequencer for one ADC channel's two deserializer lanes, running in the `lclk` domain beside the ADC/discriminator channel block. With the ADC driving a fixed test pattern, it resets the input SERDES, sweeps each lane's input-delay tap to find the widest stable window and loads its centre, then issues bitslips until the lane's word matches the expected pattern. It reports per-lane results to the control register file. The discriminator path is not trained here.

## Interface
Parameters:
- `PATTERN`, 12'hA5C: expected ADC test word. Lane 0 checks `[5:0]`; lane 1 checks `[11:6]`.
- `SETTLE`, 8: wait cycles after any tap load or bitslip. Must be ≥ 4.
- `CHECK_LEN`, 64: number of samples compared per stability or pattern check.
- `IO_RST_CYCLES`, 4: width of the `io_reset` pulse.

Ports:
- `clk`  in  1  lclk. All ports are synchronous to it.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle training request. Honoured only in IDLE.
- `adc_bits`  in  12  channel output `{lane1, lane0}`.
- `delay_tap_out_0` / `delay_tap_out_1`  in  5  tap readback per lane.
- `adc_io_reset`  out  2  SERDES io reset, both bits driven together.
- `in_delay_reset`  out  2  one-cycle pulse that loads `delay_tap_in_x` into lane x.
- `in_delay_data_ce` / `in_delay_data_inc`  out  2  held 0 (tap changes are done by load only).
- `adc_bitslip`  out  2  one-cycle bitslip pulse per lane.
- `delay_tap_in_0` / `delay_tap_in_1`  out  5  tap value to load.
- `busy`  out  1  high from `start` acceptance until DONE/FAIL.
- `done`  out  1  one-cycle pulse on success.
- `fail`  out  1  sticky until the next `start`.
- `fail_lane`  out  1  lane that failed.
- `fail_code`  out  2  1 = no stable tap, 2 = no bitslip match, 3 = tap readback mismatch.
- `win_len_0` / `win_len_1`  out  6  best window length per lane (0–32).
- `slips_0` / `slips_1`  out  3  bitslips applied per lane.

## Operation
- States: IDLE → IO_RST → LOAD → SETTLE → CHECK → NEXT → (back to LOAD, or CENTER) → CSETTLE → VERIFY → SLIP → SWAIT → MATCH → (back to SLIP, next lane's LOAD, or DONE), with FAIL reachable from the error points below.
- `start` accepted in IDLE:
  - Clear `fail`, the status outputs and the window trackers.
  - Set lane index to 0 and assert `busy`.
  - Enter IO_RST.
- IO_RST: drive `adc_io_reset`=2'b11 for `IO_RST_CYCLES` cycles, then go to LOAD with tap t=0.
- LOAD: drive `delay_tap_in_x`=t and pulse `in_delay_reset[x]` for one cycle. Then SETTLE.
- SETTLE: wait `SETTLE` cycles. Then CHECK.
- CHECK:
  - Capture the lane's 6 bits as the reference on the first cycle.
  - Compare each of the following `CHECK_LEN` samples against the reference.
  - The tap is good only if every comparison is equal.
- NEXT: update the run tracker.
  - Good tap: extend the current run.
  - Bad tap: close the current run.
  - A run replaces the best window only if strictly longer, so the earliest of equal-length windows wins.
  - Runs do not wrap from 31 to 0.
  - If t=31, go to CENTER; otherwise t+1, back to LOAD.
- CENTER:
  - If best length = 0: FAIL, code 1.
  - Otherwise centre = start + ((len−1)>>1), computed in 6 bits and truncated to 5. Load it via an `in_delay_reset` pulse, then CSETTLE (`SETTLE` cycles).
- VERIFY: if `delay_tap_out_x` ≠ centre: FAIL, code 3. Otherwise go to MATCH with slip count 0.
- MATCH: compare `CHECK_LEN` samples against the lane's `PATTERN` slice.
  - All match: latch `slips_x`. Go to lane 1's LOAD (t=0) if lane=0, or DONE if lane=1.
  - Any mismatch with slips < 5: go to SLIP.
  - Any mismatch with slips = 5: FAIL, code 2.
- SLIP: one-cycle `adc_bitslip[x]` pulse, slips+1, then SWAIT (`SETTLE` cycles), then MATCH.
- DONE: pulse `done`, drop `busy`, return to IDLE.
- FAIL: set `fail`, `fail_lane`, `fail_code`; drop `busy`; return to IDLE.
- Taps already loaded are left in place after DONE or FAIL.
- `start` while busy is ignored.

## Timing
- Reset values: all outputs 0, state IDLE.
- `reset_n` low mid-sequence: every pulse output deasserts immediately (asynchronous), the state machine returns to IDLE, and no `done` or `fail` is produced.
- All outputs are registered.
- `start` at cycle 0 gives `busy`=1 and `adc_io_reset`=2'b11 from cycle 1.
- `in_delay_reset` and `adc_bitslip` are exactly one cycle wide and never overlap each other.
- Sampling of `adc_bits` starts no earlier than `SETTLE` cycles after a load or slip, which covers the channel's 2-cycle output pipeline.
- Per-tap cost: 1 + `SETTLE` + 1 + `CHECK_LEN` cycles, plus 1 for NEXT.
- Per-lane sweep: 32 × per-tap cost.

## Test plan
- **Eye on taps 10–17, lane 0:** lane model is stable only on taps 10–17, and the pattern appears after 2 slips → tap_in_0=13, `win_len_0`=8, `slips_0`=2.
- **Eye on taps 20–24, lane 1:** lane model is stable only on taps 20–24, no slips needed → tap_in_1=22, `win_len_1`=5, `slips_1`=0, `done` pulses once, `busy` falls with it.
- **Equal-length windows:** lane 0 stable on 2–5 and 20–23 → tap 3 chosen; stable on 28–31 only → tap 29.
- **No stable tap:** lane 0 never stable → `fail`=1, `fail_lane`=0, `fail_code`=1, lane 1 never tapped.
- **Pattern never matches:** lane 1 pattern never matches → exactly 5 `adc_bitslip[1]` pulses, then `fail_code`=2, `fail_lane`=1.
- **Readback mismatch:** `delay_tap_out_0` stuck at 0 with centre 13 → `fail_code`=3.
- **Reset and restart:** `reset_n` pulsed low during lane 0 CHECK → all outputs 0 at once, no `done`; a following `start` trains normally. A second `start` while busy → no effect.

Source files
------------

// File: rtl/adc_link_trainer.sv
// adc_link_trainer
// ----------------
// Link-training sequencer for the two 6-bit deserializer lanes of one ADC
// channel. With the ADC sending a fixed test word it pulses the SERDES io
// reset, sweeps every input-delay tap of a lane to find the widest window of
// stable samples, loads the centre of that window, confirms the tap readback,
// then bitslips until the lane word equals its slice of PATTERN. Lane 0 is
// trained first, then lane 1.
//
// Handshake / pulse semantics: `start` is a single-cycle request sampled only
// in IDLE; `busy` is high from the cycle after acceptance until the cycle in
// which `done` pulses or `fail` rises. `in_delay_reset` and `adc_bitslip` are
// single-cycle strobes, never both active in one cycle.
//
// Ports:
//   clk, reset_n            lclk and asynchronous active-low reset
//   start                   training request (IDLE only)
//   adc_bits[11:0]          {lane1[5:0], lane0[5:0]} from the channel block
//   delay_tap_out_0/1[4:0]  tap readback per lane
//   adc_io_reset[1:0]       SERDES io reset (both bits together)
//   in_delay_reset[1:0]     load strobe for delay_tap_in_x
//   in_delay_data_ce/inc    tied 0; taps are only changed by load
//   adc_bitslip[1:0]        bitslip strobe per lane
//   delay_tap_in_0/1[4:0]   tap value presented with the load strobe
//   busy, done, fail        status; done is a pulse, fail is sticky
//   fail_lane, fail_code    1 = no stable tap, 2 = no match, 3 = readback
//   win_len_0/1[5:0]        best stable window length per lane
//   slips_0/1[2:0]          bitslips applied per lane
//   dbg_state[3:0]          current FSM state encoding
module adc_link_trainer #(
    parameter logic [11:0] PATTERN       = 12'hA5C,
    parameter int          SETTLE        = 8,
    parameter int          CHECK_LEN     = 64,
    parameter int          IO_RST_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [11:0] adc_bits,
    input  logic [4:0]  delay_tap_out_0,
    input  logic [4:0]  delay_tap_out_1,
    output logic [1:0]  adc_io_reset,
    output logic [1:0]  in_delay_reset,
    output logic [1:0]  in_delay_data_ce,
    output logic [1:0]  in_delay_data_inc,
    output logic [1:0]  adc_bitslip,
    output logic [4:0]  delay_tap_in_0,
    output logic [4:0]  delay_tap_in_1,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic        fail_lane,
    output logic [1:0]  fail_code,
    output logic [5:0]  win_len_0,
    output logic [5:0]  win_len_1,
    output logic [2:0]  slips_0,
    output logic [2:0]  slips_1,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_IO_RST  = 4'd1,
        S_LOAD    = 4'd2,
        S_SETTLE  = 4'd3,
        S_CHECK   = 4'd4,
        S_NEXT    = 4'd5,
        S_CENTER  = 4'd6,
        S_CSETTLE = 4'd7,
        S_VERIFY  = 4'd8,
        S_SLIP    = 4'd9,
        S_SWAIT   = 4'd10,
        S_MATCH   = 4'd11,
        S_DONE    = 4'd12,
        S_FAIL    = 4'd13
    } state_t;

    localparam logic [15:0] IO_LAST     = 16'(IO_RST_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
    // CHECK spends one cycle capturing the reference, then CHECK_LEN compares.
    localparam logic [15:0] CHECK_LAST  = 16'(CHECK_LEN);
    localparam logic [15:0] MATCH_LAST  = 16'(CHECK_LEN - 1);
    localparam logic [2:0]  MAX_SLIPS   = 3'd5;

    // State and datapath registers
    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [4:0]  tap, tap_d;
    logic        lane, lane_d;
    logic [5:0]  ref_word, ref_word_d;
    logic        good, good_d;
    logic [4:0]  run_start, run_start_d;
    logic [5:0]  run_len, run_len_d;
    logic [4:0]  best_start, best_start_d;
    logic [5:0]  best_len, best_len_d;
    logic [4:0]  centre, centre_d;
    logic [2:0]  slip_cnt, slip_cnt_d;

    // Next values of registered outputs
    logic [1:0]  io_reset_d, load_strobe_d, bitslip_d;
    logic [4:0]  tap_in_0_d, tap_in_1_d;
    logic        busy_d, done_d, fail_d, fail_lane_d;
    logic [1:0]  fail_code_d;
    logic [5:0]  win_len_0_d, win_len_1_d;
    logic [2:0]  slips_0_d, slips_1_d;

    // Combinational helpers
    logic [5:0]  lane_word;
    logic [5:0]  pat_word;
    logic [4:0]  tap_readback;
    logic        sample_eq_ref;
    logic        sample_eq_pat;
    logic [5:0]  cand_len;
    logic [4:0]  cand_start;
    logic [5:0]  centre_sum;
    logic        load_now;
    logic [4:0]  load_val;

    assign lane_word     = lane ? adc_bits[11:6] : adc_bits[5:0];
    assign pat_word      = lane ? PATTERN[11:6]  : PATTERN[5:0];
    assign tap_readback  = lane ? delay_tap_out_1 : delay_tap_out_0;
    assign sample_eq_ref = (lane_word == ref_word);
    assign sample_eq_pat = (lane_word == pat_word);

    assign in_delay_data_ce  = 2'b00;
    assign in_delay_data_inc = 2'b00;
    assign dbg_state         = state;

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        tap_d        = tap;
        lane_d       = lane;
        ref_word_d   = ref_word;
        good_d       = good;
        run_start_d  = run_start;
        run_len_d    = run_len;
        best_start_d = best_start;
        best_len_d   = best_len;
        centre_d     = centre;
        slip_cnt_d   = slip_cnt;
        busy_d       = busy;
        done_d       = 1'b0;
        fail_d       = fail;
        fail_lane_d  = fail_lane;
        fail_code_d  = fail_code;
        win_len_0_d  = win_len_0;
        win_len_1_d  = win_len_1;
        slips_0_d    = slips_0;
        slips_1_d    = slips_1;
        cand_len     = 6'd0;
        cand_start   = 5'd0;
        centre_sum   = 6'd0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_IO_RST;
                    cnt_d        = 16'd0;
                    lane_d       = 1'b0;
                    tap_d        = 5'd0;
                    run_start_d  = 5'd0;
                    run_len_d    = 6'd0;
                    best_start_d = 5'd0;
                    best_len_d   = 6'd0;
                    busy_d       = 1'b1;
                    fail_d       = 1'b0;
                    fail_lane_d  = 1'b0;
                    fail_code_d  = 2'd0;
                    win_len_0_d  = 6'd0;
                    win_len_1_d  = 6'd0;
                    slips_0_d    = 3'd0;
                    slips_1_d    = 3'd0;
                end
            end

            S_IO_RST: begin
                if (cnt == IO_LAST) begin
                    state_d = S_LOAD;
                    cnt_d   = 16'd0;
                    tap_d   = 5'd0;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end

            S_LOAD: begin
                state_d = S_SETTLE;
                cnt_d   = 16'd0;
            end

            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_d = S_CHECK;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end

            S_CHECK: begin
                if (cnt == 16'd0) begin
                    ref_word_d = lane_word;
                    good_d     = 1'b1;
                    cnt_d      = 16'd1;
                end else begin
                    good_d = good & sample_eq_ref;
                    if (cnt == CHECK_LAST) begin
                        state_d = S_NEXT;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt + 16'd1;
                    end
                end
            end

            S_NEXT: begin
                // Best is refreshed while a run grows; strict '>' keeps the
                // earliest window when two have equal length.
                if (good) begin
                    cand_len    = run_len + 6'd1;
                    cand_start  = (run_len == 6'd0) ? tap : run_start;
                    run_len_d   = cand_len;
                    run_start_d = cand_start;
                    if (cand_len > best_len) begin
                        best_len_d   = cand_len;
                        best_start_d = cand_start;
                    end
                end else begin
                    run_len_d = 6'd0;
                end
                if (tap == 5'd31) begin
                    state_d    = S_CENTER;
                    centre_sum = {1'b0, best_start_d} + ((best_len_d - 6'd1) >> 1);
                    centre_d   = centre_sum[4:0];
                    if (lane) win_len_1_d = best_len_d;
                    else      win_len_0_d = best_len_d;
                end else begin
                    tap_d   = tap + 5'd1;
                    state_d = S_LOAD;
                end
            end

            S_CENTER: begin
                if (best_len == 6'd0) begin
                    state_d     = S_FAIL;
                    fail_d      = 1'b1;
                    fail_lane_d = lane;
                    fail_code_d = 2'd1;
                    busy_d      = 1'b0;
                end else begin
                    state_d = S_CSETTLE;
                    cnt_d   = 16'd0;
                end
            end

            S_CSETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_d = S_VERIFY;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end

            S_VERIFY: begin
                if (tap_readback != centre) begin
                    state_d     = S_FAIL;
                    fail_d      = 1'b1;
                    fail_lane_d = lane;
                    fail_code_d = 2'd3;
                    busy_d      = 1'b0;
                end else begin
                    state_d    = S_MATCH;
                    cnt_d      = 16'd0;
                    slip_cnt_d = 3'd0;
                    good_d     = 1'b1;
                end
            end

            S_MATCH: begin
                if (cnt == MATCH_LAST) begin
                    cnt_d = 16'd0;
                    if (good & sample_eq_pat) begin
                        if (lane) begin
                            slips_1_d = slip_cnt;
                            state_d   = S_DONE;
                            done_d    = 1'b1;
                            busy_d    = 1'b0;
                        end else begin
                            slips_0_d    = slip_cnt;
                            lane_d       = 1'b1;
                            tap_d        = 5'd0;
                            run_start_d  = 5'd0;
                            run_len_d    = 6'd0;
                            best_start_d = 5'd0;
                            best_len_d   = 6'd0;
                            state_d      = S_LOAD;
                        end
                    end else if (slip_cnt == MAX_SLIPS) begin
                        state_d     = S_FAIL;
                        fail_d      = 1'b1;
                        fail_lane_d = lane;
                        fail_code_d = 2'd2;
                        busy_d      = 1'b0;
                    end else begin
                        state_d = S_SLIP;
                    end
                end else begin
                    good_d = good & sample_eq_pat;
                    cnt_d  = cnt + 16'd1;
                end
            end

            S_SLIP: begin
                slip_cnt_d = slip_cnt + 3'd1;
                state_d    = S_SWAIT;
                cnt_d      = 16'd0;
            end

            S_SWAIT: begin
                if (cnt == SETTLE_LAST) begin
                    state_d = S_MATCH;
                    cnt_d   = 16'd0;
                    good_d  = 1'b1;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end

            S_DONE: state_d = S_IDLE;
            S_FAIL: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the state being entered, so each one is
    // high for exactly the single cycle spent in LOAD, CENTER or SLIP.
    always_comb begin
        io_reset_d    = (state_d == S_IO_RST) ? 2'b11 : 2'b00;
        load_now      = (state_d == S_LOAD) ||
                        ((state_d == S_CENTER) && (best_len_d != 6'd0));
        load_val      = (state_d == S_CENTER) ? centre_d : tap_d;
        load_strobe_d = 2'b00;
        bitslip_d     = 2'b00;
        tap_in_0_d    = delay_tap_in_0;
        tap_in_1_d    = delay_tap_in_1;
        if (load_now) begin
            if (lane_d) begin
                load_strobe_d = 2'b10;
                tap_in_1_d    = load_val;
            end else begin
                load_strobe_d = 2'b01;
                tap_in_0_d    = load_val;
            end
        end
        if (state_d == S_SLIP) begin
            bitslip_d = lane_d ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            cnt            <= 16'd0;
            tap            <= 5'd0;
            lane           <= 1'b0;
            ref_word       <= 6'd0;
            good           <= 1'b0;
            run_start      <= 5'd0;
            run_len        <= 6'd0;
            best_start     <= 5'd0;
            best_len       <= 6'd0;
            centre         <= 5'd0;
            slip_cnt       <= 3'd0;
            adc_io_reset   <= 2'b00;
            in_delay_reset <= 2'b00;
            adc_bitslip    <= 2'b00;
            delay_tap_in_0 <= 5'd0;
            delay_tap_in_1 <= 5'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            fail_lane      <= 1'b0;
            fail_code      <= 2'd0;
            win_len_0      <= 6'd0;
            win_len_1      <= 6'd0;
            slips_0        <= 3'd0;
            slips_1        <= 3'd0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            tap            <= tap_d;
            lane           <= lane_d;
            ref_word       <= ref_word_d;
            good           <= good_d;
            run_start      <= run_start_d;
            run_len        <= run_len_d;
            best_start     <= best_start_d;
            best_len       <= best_len_d;
            centre         <= centre_d;
            slip_cnt       <= slip_cnt_d;
            adc_io_reset   <= io_reset_d;
            in_delay_reset <= load_strobe_d;
            adc_bitslip    <= bitslip_d;
            delay_tap_in_0 <= tap_in_0_d;
            delay_tap_in_1 <= tap_in_1_d;
            busy           <= busy_d;
            done           <= done_d;
            fail           <= fail_d;
            fail_lane      <= fail_lane_d;
            fail_code      <= fail_code_d;
            win_len_0      <= win_len_0_d;
            win_len_1      <= win_len_1_d;
            slips_0        <= slips_0_d;
            slips_1        <= slips_1_d;
        end
    end

endmodule

// File: tb/tb_adc_link_trainer.sv
// tb_adc_link_trainer
// -------------------
// Directed bench for adc_link_trainer. A behavioural lane model produces a
// stable word only on configured tap windows (random data elsewhere) and
// presents the pattern slice once the configured number of bitslips has been
// applied. Expected results are hand-computed per scenario.
module tb_adc_link_trainer;

    localparam logic [5:0] P0       = 6'h1C;  // 12'hA5C[5:0]
    localparam logic [5:0] P1       = 6'h29;  // 12'hA5C[11:6]
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_CHECK = 4'd4;
    localparam int         NONE_LO  = 99;
    localparam int         NONE_HI  = -1;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [11:0] adc_bits;
    logic [4:0]  delay_tap_out_0, delay_tap_out_1;
    logic [1:0]  adc_io_reset, in_delay_reset, in_delay_data_ce, in_delay_data_inc, adc_bitslip;
    logic [4:0]  delay_tap_in_0, delay_tap_in_1;
    logic        busy, done, fail, fail_lane;
    logic [1:0]  fail_code;
    logic [5:0]  win_len_0, win_len_1;
    logic [2:0]  slips_0, slips_1;
    logic [3:0]  dbg_state;

    adc_link_trainer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .adc_bits          (adc_bits),
        .delay_tap_out_0   (delay_tap_out_0),
        .delay_tap_out_1   (delay_tap_out_1),
        .adc_io_reset      (adc_io_reset),
        .in_delay_reset    (in_delay_reset),
        .in_delay_data_ce  (in_delay_data_ce),
        .in_delay_data_inc (in_delay_data_inc),
        .adc_bitslip       (adc_bitslip),
        .delay_tap_in_0    (delay_tap_in_0),
        .delay_tap_in_1    (delay_tap_in_1),
        .busy              (busy),
        .done              (done),
        .fail              (fail),
        .fail_lane         (fail_lane),
        .fail_code         (fail_code),
        .win_len_0         (win_len_0),
        .win_len_1         (win_len_1),
        .slips_0           (slips_0),
        .slips_1           (slips_1),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- lane model configuration ----------------
    int   l0_alo, l0_ahi, l0_blo, l0_bhi, l0_need;
    int   l1_alo, l1_ahi, l1_blo, l1_bhi, l1_need;
    logic stuck0;
    logic model_clear;

    int          m_slip0, m_slip1;
    logic [4:0]  m_tap0, m_tap1;

    // Monitor counters
    int   done_cnt, bs0_cnt, bs1_cnt, ld1_cnt, io_cyc, viol;
    logic prev_ldr, prev_bs;

    int n_checks;
    int n_errors;
    logic [63:0] exp_q[$];

    function automatic logic [5:0] model_word(input logic [4:0] t, input int slips,
                                              input int alo, input int ahi,
                                              input int blo, input int bhi,
                                              input int need, input logic [5:0] pat);
        int ti;
        ti = int'(t);
        if ((ti >= alo && ti <= ahi) || (ti >= blo && ti <= bhi))
            return (slips == need) ? pat : (pat ^ 6'h3F);
        return 6'($urandom);
    endfunction

    // Lane/channel model: latches loaded taps, counts bitslips, drives data.
    initial begin
        m_tap0 = 5'd0; m_tap1 = 5'd0; m_slip0 = 0; m_slip1 = 0;
        adc_bits = 12'd0; delay_tap_out_0 = 5'd0; delay_tap_out_1 = 5'd0;
        forever begin
            @(negedge clk);
            if (model_clear) begin
                m_slip0 = 0;
                m_slip1 = 0;
            end
            if (in_delay_reset[0]) m_tap0 = delay_tap_in_0;
            if (in_delay_reset[1]) m_tap1 = delay_tap_in_1;
            if (adc_bitslip[0]) m_slip0++;
            if (adc_bitslip[1]) m_slip1++;
            adc_bits = {model_word(m_tap1, m_slip1, l1_alo, l1_ahi, l1_blo, l1_bhi, l1_need, P1),
                        model_word(m_tap0, m_slip0, l0_alo, l0_ahi, l0_blo, l0_bhi, l0_need, P0)};
            delay_tap_out_0 = stuck0 ? 5'd0 : m_tap0;
            delay_tap_out_1 = m_tap1;
        end
    end

    // Protocol monitor
    initial begin
        done_cnt = 0; bs0_cnt = 0; bs1_cnt = 0; ld1_cnt = 0; io_cyc = 0; viol = 0;
        prev_ldr = 1'b0; prev_bs = 1'b0;
        forever begin
            @(negedge clk);
            if (model_clear) begin
                done_cnt = 0; bs0_cnt = 0; bs1_cnt = 0; ld1_cnt = 0; io_cyc = 0; viol = 0;
            end
            if (done) done_cnt++;
            if (adc_bitslip[0]) bs0_cnt++;
            if (adc_bitslip[1]) bs1_cnt++;
            if (in_delay_reset[1]) ld1_cnt++;
            if (adc_io_reset == 2'b11) io_cyc++;
            if (adc_io_reset == 2'b01 || adc_io_reset == 2'b10) viol++;
            if ((|in_delay_reset) && (|adc_bitslip)) viol++;
            if ((|in_delay_reset) && prev_ldr) viol++;
            if ((|adc_bitslip) && prev_bs) viol++;
            prev_ldr = |in_delay_reset;
            prev_bs  = |adc_bitslip;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic score(input string tag, input logic [63:0] got);
        logic [63:0] e;
        e = 64'hDEAD_BEEF;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check(tag, got, e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_lanes(input int a0lo, input int a0hi, input int b0lo, input int b0hi, input int n0,
                             input int a1lo, input int a1hi, input int b1lo, input int b1hi, input int n1,
                             input logic stk);
        l0_alo = a0lo; l0_ahi = a0hi; l0_blo = b0lo; l0_bhi = b0hi; l0_need = n0;
        l1_alo = a1lo; l1_ahi = a1hi; l1_blo = b1lo; l1_bhi = b1hi; l1_need = n1;
        stuck0 = stk;
    endtask

    task automatic clear_model();
        model_clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_clear = 1'b0;
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_c1"}, 64'(busy), 64'd1);
        check({tag, "_ioreset_c1"}, 64'(adc_io_reset), 64'd3);
    endtask

    task automatic wait_end(input string tag, output logic busy_at_end);
        logic seen;
        seen = 1'b0;
        busy_at_end = 1'b1;
        for (int i = 0; i < 9000 && !seen; i++) begin
            @(negedge clk);
            if (done || fail) begin
                seen = 1'b1;
                busy_at_end = busy;
            end
        end
        check({tag, "_finished"}, 64'(seen), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_state(input string tag, input logic [3:0] s);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (dbg_state == s) seen = 1'b1;
        end
        check({tag, "_reached"}, 64'(seen), 64'd1);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({adc_io_reset, in_delay_reset, in_delay_data_ce, in_delay_data_inc,
                    adc_bitslip, delay_tap_in_0, delay_tap_in_1, busy, done, fail,
                    fail_lane, fail_code, win_len_0, win_len_1, slips_0, slips_1});
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic be;
        n_checks = 0;
        n_errors = 0;
        reset_n = 1'b0;
        start = 1'b0;
        model_clear = 1'b0;
        set_lanes(10, 17, NONE_LO, NONE_HI, 2, 20, 24, NONE_LO, NONE_HI, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_outs_low", all_outs(), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_outs", all_outs(), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

        // Eyes 10-17 (2 slips) and 20-24 (no slips)
        clear_model();
        expect_val(13); expect_val(8); expect_val(2);
        expect_val(22); expect_val(5); expect_val(0);
        pulse_start("a");
        wait_end("a", be);
        check("a_busy_at_done", 64'(be), 64'd0);
        check("a_done_cnt", 64'(done_cnt), 64'd1);
        check("a_fail", 64'(fail), 64'd0);
        score("a_tap_in_0", 64'(delay_tap_in_0));
        score("a_win_len_0", 64'(win_len_0));
        score("a_slips_0", 64'(slips_0));
        score("a_tap_in_1", 64'(delay_tap_in_1));
        score("a_win_len_1", 64'(win_len_1));
        score("a_slips_1", 64'(slips_1));
        check("a_bitslip0_pulses", 64'(bs0_cnt), 64'd2);
        check("a_io_cycles", 64'(io_cyc), 64'd4);
        check("a_strobe_rules", 64'(viol), 64'd0);
        check("a_ce_inc", 64'({in_delay_data_ce, in_delay_data_inc}), 64'd0);

        // Equal-length windows 2-5 and 20-23: earliest wins
        set_lanes(2, 5, 20, 23, 0, 20, 24, NONE_LO, NONE_HI, 0, 1'b0);
        clear_model();
        expect_val(3); expect_val(4);
        pulse_start("b");
        wait_end("b", be);
        score("b_tap_in_0", 64'(delay_tap_in_0));
        score("b_win_len_0", 64'(win_len_0));
        check("b_done_cnt", 64'(done_cnt), 64'd1);

        // Window at the top edge 28-31
        set_lanes(28, 31, NONE_LO, NONE_HI, 0, 20, 24, NONE_LO, NONE_HI, 0, 1'b0);
        clear_model();
        expect_val(29); expect_val(4);
        pulse_start("c");
        wait_end("c", be);
        score("c_tap_in_0", 64'(delay_tap_in_0));
        score("c_win_len_0", 64'(win_len_0));

        // Lane 0 never stable
        set_lanes(NONE_LO, NONE_HI, NONE_LO, NONE_HI, 0, 20, 24, NONE_LO, NONE_HI, 0, 1'b0);
        clear_model();
        pulse_start("d");
        wait_end("d", be);
        check("d_busy_at_fail", 64'(be), 64'd0);
        check("d_fail", 64'({fail, fail_lane, fail_code}), 64'({1'b1, 1'b0, 2'd1}));
        check("d_lane1_loads", 64'(ld1_cnt), 64'd0);
        check("d_no_done", 64'(done_cnt), 64'd0);
        check("d_win_len_0", 64'(win_len_0), 64'd0);

        // Lane 1 pattern never matches
        set_lanes(10, 17, NONE_LO, NONE_HI, 0, 20, 24, NONE_LO, NONE_HI, 7, 1'b0);
        clear_model();
        pulse_start("e");
        wait_end("e", be);
        check("e_fail", 64'({fail, fail_lane, fail_code}), 64'({1'b1, 1'b1, 2'd2}));
        check("e_bitslip1_pulses", 64'(bs1_cnt), 64'd5);
        check("e_tap_in_1", 64'(delay_tap_in_1), 64'd22);
        check("e_strobe_rules", 64'(viol), 64'd0);

        // Readback stuck at 0
        set_lanes(10, 17, NONE_LO, NONE_HI, 0, 20, 24, NONE_LO, NONE_HI, 0, 1'b1);
        clear_model();
        pulse_start("f");
        wait_end("f", be);
        check("f_fail", 64'({fail, fail_lane, fail_code}), 64'({1'b1, 1'b0, 2'd3}));
        check("f_tap_in_0", 64'(delay_tap_in_0), 64'd13);

        // Reset during lane 0 CHECK
        set_lanes(10, 17, NONE_LO, NONE_HI, 2, 20, 24, NONE_LO, NONE_HI, 0, 1'b0);
        clear_model();
        pulse_start("g");
        wait_state("g", ST_CHECK);
        repeat (20) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("g_outs_async", all_outs(), 64'd0);
        check("g_state_async", 64'(dbg_state), 64'(ST_IDLE));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("g_no_done_fail", 64'({done_cnt[7:0], fail}), 64'd0);
        check("g_idle_after", 64'(dbg_state), 64'(ST_IDLE));

        // Restart, with a second start while busy
        clear_model();
        pulse_start("h");
        wait_state("h", ST_CHECK);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("h", be);
        check("h_done_cnt", 64'(done_cnt), 64'd1);
        check("h_io_cycles", 64'(io_cyc), 64'd4);
        check("h_taps", 64'({delay_tap_in_0, delay_tap_in_1}), 64'({5'd13, 5'd22}));
        check("h_slips", 64'({slips_0, slips_1}), 64'({3'd2, 3'd0}));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
